// File: rtl/ds_dac_multi_if.sv
// rtl/ds_dac_multi_if.sv - sample handshake, control and 1-bit output bundle for ds_dac_multi
interface ds_dac_multi_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
);
  logic [CHANNELS*WIDTH-1:0] sample_i;
  logic                      sample_valid_i;
  logic                      sample_ready_o;
  logic                      signed_i;
  logic                      mute_i;
  logic                      mode_i;
  logic                      muted_o;
  logic [CHANNELS-1:0]       dac_o;

  // Sample source / controller side
  modport master (
    output sample_i, sample_valid_i, signed_i, mute_i, mode_i,
    input  sample_ready_o, muted_o, dac_o
  );

  // DAC side
  modport slave (
    input  sample_i, sample_valid_i, signed_i, mute_i, mode_i,
    output sample_ready_o, muted_o, dac_o
  );
endinterface

// File: rtl/ds_dac_multi.sv
// rtl/ds_dac_multi.sv - multi-channel delta-sigma DAC with double-buffered input, mute ramp and 1st/2nd-order modulators
module ds_dac_multi #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 8,
  parameter int UPDATE_DIV = 16,
  parameter int GAIN_BITS  = 4
) (
  input  logic          clk_i,
  input  logic          res_n_i,
  ds_dac_multi_if.slave bus
);
  localparam int CW = $clog2(UPDATE_DIV);
  localparam int GW = GAIN_BITS + 1;
  localparam int IW = WIDTH + 4;
  localparam int SW = WIDTH + 6;
  localparam int PW = WIDTH + GW + 2;
  localparam int DW = CHANNELS * WIDTH;

  localparam logic [CW-1:0]        CNT_LAST = CW'(UPDATE_DIV - 1);
  localparam logic [GW-1:0]        G_FULL   = GW'(2 ** GAIN_BITS);
  localparam logic [WIDTH-1:0]     MID      = WIDTH'(2 ** (WIDTH - 1));
  localparam logic signed [SW-1:0] I_MAX    = SW'(2 ** (IW - 1) - 1);
  localparam logic signed [SW-1:0] I_MIN    = SW'(-(2 ** (IW - 1)));
  localparam logic signed [SW-1:0] FB_ONE   = SW'(2 ** WIDTH);

  // Integrators clamp instead of wrapping so a full-scale input cannot flip the loop sign
  function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > I_MAX) return I_MAX[IW-1:0];
    if (v < I_MIN) return I_MIN[IW-1:0];
    return v[IW-1:0];
  endfunction

  logic [CW-1:0] cnt_q;
  logic          tick;

  assign tick = (cnt_q == CNT_LAST);

  // Update-tick divider: one tick every UPDATE_DIV clocks
  always_ff @(posedge clk_i) begin
    if (!res_n_i)  cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + CW'(1);
  end

  logic [DW-1:0] conv;
  logic [DW-1:0] pending_q;
  logic [DW-1:0] active_q;
  logic          pending_full_q;
  logic          ready_q;
  logic          accept;

  assign accept = bus.sample_valid_i & ready_q;

  // Flipping each channel MSB maps two's complement onto offset binary
  always_comb begin
    conv = bus.sample_i;
    if (bus.signed_i) begin
      for (int n = 0; n < CHANNELS; n++) begin
        conv[n*WIDTH+WIDTH-1] = ~bus.sample_i[n*WIDTH+WIDTH-1];
      end
    end
  end

  // Double buffer: capture into pending, promote to active only on a tick
  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      pending_q      <= {CHANNELS{MID}};
      active_q       <= {CHANNELS{MID}};
      pending_full_q <= 1'b0;
      ready_q        <= 1'b0;
    end else begin
      if (tick && pending_full_q) active_q <= pending_q;
      // ready_q implies pending is empty, so accept and promotion never coincide
      if (accept) begin
        pending_q      <= conv;
        pending_full_q <= 1'b1;
        ready_q        <= 1'b0;
      end else if (tick && pending_full_q) begin
        pending_full_q <= 1'b0;
        ready_q        <= 1'b1;
      end else begin
        ready_q        <= !pending_full_q;
      end
    end
  end

  logic [GW-1:0] g_q;
  logic [GW-1:0] g_next;
  logic          muted_q;

  // One gain step per tick toward 0 or full scale, saturating at both ends
  always_comb begin
    g_next = g_q;
    if (tick) begin
      if (bus.mute_i) begin
        if (g_q != '0) g_next = g_q - GW'(1);
      end else if (g_q != G_FULL) begin
        g_next = g_q + GW'(1);
      end
    end
  end

  // Gain register and its registered zero flag
  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      g_q     <= '0;
      muted_q <= 1'b1;
    end else begin
      g_q     <= g_next;
      muted_q <= (g_next == '0);
    end
  end

  logic mode_q;
  logic mode_chg;

  assign mode_chg = (bus.mode_i != mode_q);

  // Registered copy of mode_i used to detect a modulator switch
  always_ff @(posedge clk_i) begin
    if (!res_n_i) mode_q <= 1'b0;
    else          mode_q <= bus.mode_i;
  end

  logic [CHANNELS-1:0] dac_q;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [WIDTH-1:0]        act;
    logic [WIDTH-1:0]        x;
    logic signed [WIDTH:0]   d;
    logic signed [PW-1:0]    prod;
    logic [WIDTH-1:0]        acc_q;
    logic [WIDTH:0]          sum1;
    logic signed [SW-1:0]    fb;
    logic signed [IW-1:0]    i1_q;
    logic signed [IW-1:0]    i2_q;
    logic signed [IW-1:0]    i1_n;
    logic signed [IW-1:0]    i2_n;
    logic                    dac_bit_q;

    assign act  = active_q[n*WIDTH +: WIDTH];
    assign d    = $signed({1'b0, act}) - $signed({1'b0, MID});
    assign prod = PW'(d) * PW'($signed({1'b0, g_q}));
    // Arithmetic shift floors toward -inf; result always fits 0..2^WIDTH-1
    assign x    = MID + WIDTH'(prod >>> GAIN_BITS);

    assign sum1 = {1'b0, acc_q} + {1'b0, x};
    assign fb   = dac_bit_q ? FB_ONE : '0;
    assign i1_n = sat(SW'(i1_q) + SW'($signed({1'b0, x})) - fb);
    assign i2_n = sat(SW'(i2_q) + SW'(i1_q) - fb);

    // Modulator state; a mode switch restarts both loops from zero with output low
    always_ff @(posedge clk_i) begin
      if (!res_n_i || mode_chg) begin
        acc_q     <= '0;
        i1_q      <= '0;
        i2_q      <= '0;
        dac_bit_q <= 1'b0;
      end else begin
        acc_q     <= sum1[WIDTH-1:0];
        i1_q      <= i1_n;
        i2_q      <= i2_n;
        dac_bit_q <= bus.mode_i ? ~i2_n[IW-1] : sum1[WIDTH];
      end
    end

    assign dac_q[n] = dac_bit_q;
  end

  assign bus.sample_ready_o = ready_q;
  assign bus.muted_o        = muted_q;
  assign bus.dac_o          = dac_q;
endmodule

// File: tb/tb_ds_dac_multi.sv
// tb/tb_ds_dac_multi.sv - self-checking bench for ds_dac_multi
module tb_ds_dac_multi;
  localparam int CH  = 2;
  localparam int W   = 8;
  localparam int DIV = 16;
  localparam int GB  = 4;
  localparam int MIDV = 2 ** (W - 1);
  localparam int IHI  = 2 ** (W + 3) - 1;
  localparam int ILO  = -(2 ** (W + 3));

  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  ds_dac_multi_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  ds_dac_multi #(
    .CHANNELS(CH), .WIDTH(W), .UPDATE_DIV(DIV), .GAIN_BITS(GB)
  ) dut (
    .clk_i  (clk),
    .res_n_i(res_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;

  // ---------------- behavioural model ----------------
  int              m_cnt, m_g;
  int              m_ph[CH], m_i1[CH], m_i2[CH];
  logic [CH-1:0]   m_out;
  logic            m_ready, m_muted, m_mode_q;
  logic            m_live = 1'b0;
  logic [W-1:0]    m_act[CH];
  logic [CH*W-1:0] m_pend[$];

  function automatic int clampi(input int v);
    if (v > IHI) return IHI;
    if (v < ILO) return ILO;
    return v;
  endfunction

  always @(posedge clk) begin : model
    int x, fb, n1, n2;
    logic tk, acc_now;
    logic [CH*W-1:0] cs;
    if (!res_n) begin
      m_cnt = 0; m_g = 0; m_muted = 1'b1; m_ready = 1'b0; m_mode_q = 1'b0;
      m_out = '0;
      m_pend.delete();
      for (int c = 0; c < CH; c++) begin
        m_act[c] = W'(MIDV); m_ph[c] = 0; m_i1[c] = 0; m_i2[c] = 0;
      end
    end else begin
      tk = (m_cnt == DIV - 1);
      acc_now = bus.sample_valid_i && m_ready;
      for (int c = 0; c < CH; c++) begin
        x = MIDV + (((int'(m_act[c]) - MIDV) * m_g) >>> GB);
        if (bus.mode_i != m_mode_q) begin
          m_ph[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_out[c] = 1'b0;
        end else if (bus.mode_i) begin
          fb = m_out[c] ? 2 ** W : 0;
          n1 = clampi(m_i1[c] + x - fb);
          n2 = clampi(m_i2[c] + m_i1[c] - fb);
          m_i1[c] = n1; m_i2[c] = n2;
          m_out[c] = (n2 >= 0);
        end else begin
          m_ph[c] = m_ph[c] + x;
          m_out[c] = (m_ph[c] >= 2 ** W);
          m_ph[c] = m_ph[c] % (2 ** W);
        end
      end
      m_mode_q = bus.mode_i;
      if (tk && m_pend.size() > 0) begin
        cs = m_pend.pop_front();
        for (int c = 0; c < CH; c++) m_act[c] = cs[c*W +: W];
      end
      if (acc_now) begin
        cs = bus.sample_i;
        if (bus.signed_i) for (int c = 0; c < CH; c++) cs[c*W+W-1] = ~cs[c*W+W-1];
        m_pend.push_back(cs);
      end
      if (tk) m_g = bus.mute_i ? ((m_g > 0) ? m_g - 1 : 0) : ((m_g < 2 ** GB) ? m_g + 1 : m_g);
      m_muted = (m_g == 0);
      m_ready = (m_pend.size() == 0);
      m_cnt = (m_cnt + 1) % DIV;
    end
    m_live = 1'b1;
  end

  // Accepted transfers seen at the DUT boundary
  always @(posedge clk) begin
    if (res_n && bus.sample_valid_i && bus.sample_ready_o) acc_cnt++;
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (m_live) begin
      n_cmp++;
      if (bus.dac_o !== m_out) begin
        n_err++;
        if (n_err <= 30) $display("FAIL model_dac t=%0t: got %b, want %b", $time, bus.dac_o, m_out);
      end
      n_cmp++;
      if (bus.sample_ready_o !== m_ready) begin
        n_err++;
        if (n_err <= 30) $display("FAIL model_ready t=%0t: got %b, want %b", $time, bus.sample_ready_o, m_ready);
      end
      n_cmp++;
      if (bus.muted_o !== m_muted) begin
        n_err++;
        if (n_err <= 30) $display("FAIL model_muted t=%0t: got %b, want %b", $time, bus.muted_o, m_muted);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic window(input int n, output int c0, output int c1);
    c0 = 0; c1 = 0;
    repeat (n) begin
      @(negedge clk);
      c0 += int'(bus.dac_o[0]);
      c1 += int'(bus.dac_o[1]);
    end
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    while (!bus.sample_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(name, int'(bus.sample_ready_o), 1, 1);
  endtask

  task automatic send(input logic [CH*W-1:0] s);
    wait_ready("send_ready");
    bus.sample_i = s;
    bus.sample_valid_i = 1'b1;
    @(negedge clk);
    bus.sample_valid_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish before limit");
    $fatal(1);
  end

  initial begin
    int c0, c1, a0, t;
    bus.sample_i = 16'h8080;
    bus.sample_valid_i = 1'b0;
    bus.signed_i = 1'b0;
    bus.mute_i = 1'b0;
    bus.mode_i = 1'b0;
    res_n = 1'b0;

    step(3);
    chk("reset_dac", int'(bus.dac_o), 0, 0);
    chk("reset_ready", int'(bus.sample_ready_o), 0, 0);
    chk("reset_muted", int'(bus.muted_o), 1, 1);
    res_n = 1'b1;
    step(1);
    chk("ready_after_release", int'(bus.sample_ready_o), 1, 1);
    step(14);
    chk("muted_before_first_tick", int'(bus.muted_o), 1, 1);
    step(1);
    chk("unmuted_after_first_tick", int'(bus.muted_o), 0, 0);

    // First-order densities at full gain
    send(16'hFF40);
    step(300);
    window(256, c0, c1);
    chk("fo_ch0_40", c0, 64, 64);
    chk("fo_ch1_ff", c1, 255, 255);
    send(16'h0040);
    step(40);
    window(256, c0, c1);
    chk("fo_ch1_00", c1, 0, 0);

    // Two's-complement input
    bus.signed_i = 1'b1;
    send(16'h8000);
    step(40);
    window(256, c0, c1);
    chk("signed_ch0_00", c0, 128, 128);
    chk("signed_ch1_80", c1, 0, 0);
    bus.signed_i = 1'b0;

    // Valid held across two samples
    wait_ready("hs_start_ready");
    a0 = acc_cnt;
    bus.sample_i = 16'h00C0;
    bus.sample_valid_i = 1'b1;
    step(1);
    chk("hs_ready_low_after_a", int'(bus.sample_ready_o), 0, 0);
    bus.sample_i = 16'hFF20;
    t = 0;
    while (!bus.sample_ready_o && t < 64) begin
      step(1);
      t++;
    end
    chk("hs_ready_returns", int'(bus.sample_ready_o), 1, 1);
    step(1);
    bus.sample_valid_i = 1'b0;
    chk("hs_accept_count", acc_cnt - a0, 2, 2);
    step(40);
    window(256, c0, c1);
    chk("hs_b_ch0", c0, 32, 32);
    chk("hs_b_ch1", c1, 255, 255);

    // Accept on the tick cycle with pending empty stays in pending
    wait_ready("tick_hold_ready_before");
    t = 0;
    while (m_cnt != DIV - 1 && t < 40) begin
      step(1);
      t++;
    end
    bus.sample_i = 16'h10E0;
    bus.sample_valid_i = 1'b1;
    step(1);
    bus.sample_valid_i = 1'b0;
    chk("tick_hold_ready_low", int'(bus.sample_ready_o), 0, 0);
    step(8);
    chk("tick_hold_still_pending", int'(bus.sample_ready_o), 0, 0);
    step(40);

    // Mute ramp down and back up
    send(16'h80FF);
    step(40);
    window(256, c0, c1);
    chk("mute_pre_ch0", c0, 255, 255);
    bus.mute_i = 1'b1;
    step(272);
    chk("mute_muted", int'(bus.muted_o), 1, 1);
    window(256, c0, c1);
    chk("mute_ch0_mid", c0, 128, 128);
    chk("mute_ch1_mid", c1, 128, 128);
    bus.mute_i = 1'b0;
    step(272);
    chk("unmute_not_muted", int'(bus.muted_o), 0, 0);
    window(256, c0, c1);
    chk("unmute_ch0_full", c0, 255, 255);

    // Second-order modulator
    send(16'hFF40);
    step(40);
    bus.mode_i = 1'b1;
    step(1);
    chk("so_switch_dac_low", int'(bus.dac_o), 0, 0);
    step(64);
    window(1024, c0, c1);
    chk("so_ch0_40", c0, 254, 258);
    send(16'h0000);
    step(300);
    send(16'hFF00);
    step(300);

    // Reset in the middle of activity
    res_n = 1'b0;
    bus.mode_i = 1'b0;
    step(3);
    chk("midreset_dac", int'(bus.dac_o), 0, 0);
    chk("midreset_ready", int'(bus.sample_ready_o), 0, 0);
    chk("midreset_muted", int'(bus.muted_o), 1, 1);
    res_n = 1'b1;
    step(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ds_dac_multi.md
Name: ds_dac_multi

Overview:
- Parametrised multi-channel delta-sigma audio DAC. Successor to the single-channel 8-bit ds_dac used for the sound board output.
- Adds configurable channel count and width, and a valid/ready sample handshake with double buffering.
- Adds signed/unsigned input, a click-free mute gain ramp toward midscale, and selectable 1st/2nd-order modulation.
- Sits between sound CPU DAC latches (or future mixers) and the 1-bit audio pins; runs on the board system clock.

Parameters:
- CHANNELS, 2, number of independent output channels.
- WIDTH, 8, sample width per channel.
- UPDATE_DIV, 16, clk_i cycles per update tick (sample transfer and gain step); must be ≥2.
- GAIN_BITS, 4, gain resolution; gain g ranges 0..2^GAIN_BITS.

Ports:
- clk_i  input  1  system clock; single clock domain.
- res_n_i  input  1  synchronous active-low reset.
- sample_i  input  CHANNELS*WIDTH  packed samples; channel n at bits [n*WIDTH +: WIDTH].
- sample_valid_i  input  1  sample_i valid.
- sample_ready_o  output  1  pending buffer empty; can accept.
- signed_i  input  1  1 = two's-complement samples, 0 = offset binary.
- mute_i  input  1  1 = ramp gain to 0, 0 = ramp gain to full.
- mode_i  input  1  0 = first-order modulator, 1 = second-order.
- muted_o  output  1  gain currently 0.
- dac_o  output  CHANNELS  1-bit modulator outputs.

Behaviour:
- Reset (res_n_i low at a clk_i edge):
  - dac_o=0, sample_ready_o=0, muted_o=1.
  - g=0; active and pending samples = midscale 2^(WIDTH-1); pending_full=0.
  - Tick counter and all integrators cleared.
  - sample_ready_o=1 from the first cycle after release.
- Tick counter: counts 0..UPDATE_DIV-1 and wraps. tick=1 when count==UPDATE_DIV-1. Reset mid-count restarts at 0.
- Handshake:
  - Accept when sample_valid_i & sample_ready_o. Sign conversion (MSB inverted when signed_i=1) is applied on capture; the result goes to pending, pending_full=1, and ready drops next cycle.
  - On tick with pending_full=1: pending moves to active, pending_full=0, ready=1 next cycle.
  - Accept and tick in the same cycle with pending empty: tick transfers nothing; the sample loads pending.
  - No sample is ever dropped or duplicated.
- Gain ramp:
  - On each tick, g moves one step toward 0 (mute_i=1) or toward 2^GAIN_BITS (mute_i=0), saturating at both ends.
  - muted_o = (g==0), registered.
- Scaling per channel, combinational from active and g:
  - d = active − 2^(WIDTH-1), signed WIDTH+1 bits.
  - x = 2^(WIDTH-1) + ((d*g) >>> GAIN_BITS), arithmetic shift.
  - x stays within 0..2^WIDTH−1. g=full gives x=active exactly; g=0 gives midscale.
- First-order (mode_i=0):
  - acc is WIDTH+1 bits. acc <= {0, acc[WIDTH-1:0]} + x; dac_o[n] <= acc carry (bit WIDTH of the new sum).
  - For constant x, ones in any 2^WIDTH consecutive cycles = x exactly.
- Second-order (mode_i=1):
  - Signed integrators i1, i2, each WIDTH+4 bits. fb = dac_o[n] ? 2^WIDTH : 0.
  - i1 <= i1 + x − fb; i2 <= i2 + i1 − fb; dac_o[n] <= (i2_next ≥ 0).
  - Integrators saturate, never wrap.
- Mode change: any cycle where mode_i differs from its registered copy clears all accumulators/integrators and forces dac_o=0 that cycle. The modulator restarts next cycle.
- Channels are fully independent except the shared handshake, tick and gain.

Test Plan:
- Reset: hold res_n_i low 3 cycles mid-stream → dac_o=0, sample_ready_o=0, muted_o=1. Release with mute_i=0 → ready=1 next cycle; muted_o=0 after first tick; g=16 after 16 ticks (256 cycles).
- First-order density (WIDTH=8, g=16, mode 0):
  - ch0=0x40 → exactly 64 ones per 256-cycle window.
  - ch1=0xFF → exactly 255 ones.
  - ch1=0x00 → 0 ones.
- Signed input: signed_i=1, ch0=0x00 → 128/256 ones; ch0=0x80 → 0/256 ones.
- Handshake: valid held high with samples A then B → A accepted, ready=0 until tick. B is accepted the cycle ready returns and becomes active at the following tick; count exactly 2 accepts. Also assert valid on the tick cycle with pending empty → sample held in pending, not active.
- Mute: ch0=0xFF at full gain, assert mute_i → density falls monotonically per tick. After 16 ticks: 128/256 ones, muted_o=1. Deassert → density returns to 255/256 after 16 ticks.
- Second-order: mode_i 0→1 with ch0=0x40 → dac_o=0 on the switch cycle. Over the next 1024 cycles (after 64-cycle settle): 256±2 ones; no integrator overflow at 0x00/0xFF.
